// File: rtl/rr_sel_pkg.sv
// Shared constants, state type and helpers for the round-robin mux-select sequencer.
package rr_sel_pkg;

  // Number of competing channels (mux inputs j/k/l/m -> 0/1/2/3)
  localparam int N_CH  = 4;
  // Width of the mux select
  localparam int SEL_W = 2;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // One-hot decode of a channel index into a grant vector
  function automatic logic [N_CH-1:0] onehot(input logic [SEL_W-1:0] s);
    logic [N_CH-1:0] v;
    v    = '0;
    v[s] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, ascending mod 4.
module rr_pick
  import rr_sel_pkg::*;
(
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic             valid,
  output logic [SEL_W-1:0] win
);

  logic [SEL_W-1:0] idx;

  // Scan from ptr upward with natural 2-bit wrap; the first hit wins
  always_comb begin
    valid = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 0; i < N_CH; i++) begin
      idx = ptr + SEL_W'(i);
      if (!valid && req[idx]) begin
        valid = 1'b1;
        win   = idx;
      end
    end
  end

endmodule

// File: rtl/rr_sel_sequencer.sv
// Round-robin sequencer producing the registered select for a downstream 4:1 mux.
// Each grant is held for at most HOLD_CYCLES cycles, or until its request drops,
// after which the released channel becomes lowest priority.
module rr_sel_sequencer
  import rr_sel_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  req,
  output logic [SEL_W-1:0] sel,
  output logic [N_CH-1:0]  grant,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [CNT_W-1:0] cnt;

  logic             rel;
  logic [SEL_W-1:0] pick_ptr;
  logic             pick_valid;
  logic [SEL_W-1:0] pick_win;

  // Release on hold expiry or when the granted channel drops its request;
  // a coincident expiry and drop is still a single release.
  always_comb begin
    rel = (state == ST_GRANT) && ((cnt == HOLD_LAST) || !req[sel]);
  end

  // On a release the search must already start past the released channel,
  // so the pointer update is forwarded into the same-edge arbitration.
  always_comb begin
    pick_ptr = rel ? (sel + 1'b1) : ptr;
  end

  rr_pick u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .valid (pick_valid),
    .win   (pick_win)
  );

  // Grant FSM, hold counter and rotation pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      sel   <= '0;
      grant <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      done <= rel;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            grant <= onehot(pick_win);
            sel   <= pick_win;
            busy  <= 1'b1;
            cnt   <= '0;
            state <= ST_GRANT;
          end else begin
            grant <= '0;
            busy  <= 1'b0;
          end
        end
        ST_GRANT: begin
          if (rel) begin
            ptr <= sel + 1'b1;
            if (pick_valid) begin
              grant <= onehot(pick_win);
              sel   <= pick_win;
              cnt   <= '0;
            end else begin
              // sel deliberately keeps the released channel
              grant <= '0;
              busy  <= 1'b0;
              cnt   <= '0;
              state <= ST_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_sel_sequencer.sv
// Self-checking bench for rr_sel_sequencer: directed scenarios plus a randomized
// run compared against a behavioural owner/held-cycles model.
module tb_rr_sel_sequencer;

  localparam int HOLD = 4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  // Behavioural model: which channel owns the mux and for how many cycles
  int m_owner;   // -1 when idle
  int m_held;    // cycles the current owner has been visible
  int m_ptr;
  int m_sel;
  bit m_done;

  rr_sel_sequencer #(.HOLD_CYCLES(HOLD)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .sel   (sel),
    .grant (grant),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pick(input int p, input logic [3:0] r);
    for (int k = 0; k < 4; k++) begin
      int c;
      c = (p + k) % 4;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  function automatic void model_step(input logic [3:0] r, input logic rr);
    int w;
    if (rr) begin
      m_owner = -1; m_held = 0; m_ptr = 0; m_sel = 0; m_done = 0;
      return;
    end
    m_done = 0;
    if (m_owner < 0) begin
      w = pick(m_ptr, r);
      if (w >= 0) begin m_owner = w; m_held = 1; m_sel = w; end
    end else if (m_held == HOLD || !r[m_owner]) begin
      m_done = 1;
      m_ptr  = (m_owner + 1) % 4;
      w = pick(m_ptr, r);
      if (w >= 0) begin m_owner = w; m_held = 1; m_sel = w; end
      else m_owner = -1;
    end else begin
      m_held++;
    end
  endfunction

  // Apply one cycle of stimulus, advance the model, and leave time 1 past the edge
  task automatic drive_step(input logic [3:0] r, input logic rr);
    @(negedge clk);
    req = r;
    rst = rr;
    @(posedge clk);
    model_step(r, rr);
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      drive_step(4'b1111, 1'b1);
      checks++;
      if ({sel, grant, busy, done} !== 8'h00) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: sel=%0d grant=%b busy=%b done=%b, want all zero", k, sel, grant, busy, done);
      end
    end
    for (int k = 0; k < 4; k++) begin
      drive_step(4'b0000, 1'b0);
      checks++;
      if ({sel, grant, busy, done} !== 8'h00) begin
        errors++;
        $display("FAIL idle_after_reset cyc%0d: sel=%0d grant=%b busy=%b done=%b, want all zero", k, sel, grant, busy, done);
      end
    end
  endtask

  task automatic test_single();
    int n_done = 0;
    for (int k = 1; k <= 13; k++) begin
      logic exp_done;
      drive_step(4'b0100, 1'b0);
      exp_done = (k > 1) && ((k - 1) % HOLD == 0);
      if (done === 1'b1) n_done++;
      checks++;
      if (sel !== 2'd2 || grant !== 4'b0100 || busy !== 1'b1 || done !== exp_done) begin
        errors++;
        $display("FAIL single edge%0d: sel=%0d grant=%b busy=%b done=%b, want sel=2 grant=0100 busy=1 done=%b", k, sel, grant, busy, done, exp_done);
      end
    end
    checks++;
    if (n_done != 3) begin
      errors++;
      $display("FAIL single_done_count: got %0d, want 3", n_done);
    end
    drive_step(4'b0000, 1'b0);
    checks++;
    if (sel !== 2'd2 || grant !== 4'b0000 || busy !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL single_drop: sel=%0d grant=%b busy=%b done=%b, want sel=2 grant=0000 busy=0 done=1", sel, grant, busy, done);
    end
    drive_step(4'b0000, 1'b0);
    checks++;
    if (sel !== 2'd2 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: sel=%0d busy=%b done=%b, want sel=2 busy=0 done=0", sel, busy, done);
    end
  endtask

  task automatic test_rotation();
    drive_step(4'b1111, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      logic [1:0] exp_sel;
      logic [3:0] exp_grant;
      logic       exp_done;
      drive_step(4'b1111, 1'b0);
      exp_sel   = 2'(((k - 1) / HOLD) % 4);
      exp_grant = 4'b0001 << exp_sel;
      exp_done  = (k > 1) && ((k - 1) % HOLD == 0);
      checks++;
      if (sel !== exp_sel || grant !== exp_grant || busy !== 1'b1 || done !== exp_done) begin
        errors++;
        $display("FAIL rotation edge%0d: sel=%0d grant=%b busy=%b done=%b, want sel=%0d grant=%b busy=1 done=%b", k, sel, grant, busy, done, exp_sel, exp_grant, exp_done);
      end
    end
  endtask

  task automatic test_early_drop();
    drive_step(4'b0000, 1'b1);
    drive_step(4'b0010, 1'b0);
    drive_step(4'b0010, 1'b0);
    checks++;
    if (sel !== 2'd1 || grant !== 4'b0010 || done !== 1'b0) begin
      errors++;
      $display("FAIL early_grant: sel=%0d grant=%b done=%b, want sel=1 grant=0010 done=0", sel, grant, done);
    end
    drive_step(4'b1000, 1'b0);
    checks++;
    if (sel !== 2'd3 || grant !== 4'b1000 || busy !== 1'b1 || done !== 1'b1) begin
      errors++;
      $display("FAIL early_switch: sel=%0d grant=%b busy=%b done=%b, want sel=3 grant=1000 busy=1 done=1", sel, grant, busy, done);
    end
    for (int k = 2; k <= 5; k++) begin
      logic exp_done;
      drive_step(4'b1000, 1'b0);
      exp_done = (k == 5);
      checks++;
      if (grant !== 4'b1000 || sel !== 2'd3 || done !== exp_done) begin
        errors++;
        $display("FAIL early_hold cyc%0d: sel=%0d grant=%b done=%b, want sel=3 grant=1000 done=%b", k, sel, grant, done, exp_done);
      end
    end
  endtask

  task automatic test_wrap();
    drive_step(4'b0000, 1'b1);
    drive_step(4'b0100, 1'b0);
    drive_step(4'b1001, 1'b0);
    checks++;
    if (sel !== 2'd3 || grant !== 4'b1000 || done !== 1'b1) begin
      errors++;
      $display("FAIL wrap_to_ch3: sel=%0d grant=%b done=%b, want sel=3 grant=1000 done=1", sel, grant, done);
    end
    for (int k = 0; k < 3; k++) drive_step(4'b1001, 1'b0);
    checks++;
    if (sel !== 2'd3 || grant !== 4'b1000 || done !== 1'b0) begin
      errors++;
      $display("FAIL wrap_hold: sel=%0d grant=%b done=%b, want sel=3 grant=1000 done=0", sel, grant, done);
    end
    drive_step(4'b1001, 1'b0);
    checks++;
    if (sel !== 2'd0 || grant !== 4'b0001 || busy !== 1'b1 || done !== 1'b1) begin
      errors++;
      $display("FAIL wrap_to_ch0: sel=%0d grant=%b busy=%b done=%b, want sel=0 grant=0001 busy=1 done=1", sel, grant, busy, done);
    end
  endtask

  task automatic test_reset_mid_grant();
    drive_step(4'b0000, 1'b1);
    drive_step(4'b0100, 1'b0);
    checks++;
    if (sel !== 2'd2 || grant !== 4'b0100) begin
      errors++;
      $display("FAIL midrst_grant: sel=%0d grant=%b, want sel=2 grant=0100", sel, grant);
    end
    drive_step(4'b0100, 1'b1);
    checks++;
    if ({sel, grant, busy, done} !== 8'h00) begin
      errors++;
      $display("FAIL midrst_kill: sel=%0d grant=%b busy=%b done=%b, want all zero", sel, grant, busy, done);
    end
    drive_step(4'b0110, 1'b0);
    checks++;
    if (sel !== 2'd1 || grant !== 4'b0010 || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL midrst_ptr0: sel=%0d grant=%b busy=%b done=%b, want sel=1 grant=0010 busy=1 done=0", sel, grant, busy, done);
    end
  endtask

  task automatic test_random();
    logic [3:0] r;
    r = 4'b0000;
    drive_step(4'b0000, 1'b1);
    for (int k = 0; k < 600; k++) begin
      logic       rr;
      logic [3:0] exp_grant;
      logic       exp_busy;
      if ($urandom_range(0, 3) == 0) r = 4'($urandom);
      rr = ($urandom_range(0, 63) == 0);
      drive_step(r, rr);
      exp_grant = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
      exp_busy  = (m_owner >= 0);
      checks++;
      if (sel !== 2'(m_sel) || grant !== exp_grant || busy !== exp_busy || done !== m_done) begin
        errors++;
        $display("FAIL random cyc%0d req=%b rst=%b: sel=%0d grant=%b busy=%b done=%b, want sel=%0d grant=%b busy=%b done=%b",
                 k, r, rr, sel, grant, busy, done, m_sel, exp_grant, exp_busy, m_done);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    m_owner = -1; m_held = 0; m_ptr = 0; m_sel = 0; m_done = 0;
    test_reset();
    test_single();
    test_rotation();
    test_early_drop();
    test_wrap();
    test_reset_mid_grant();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_sel_sequencer.md
Name: rr_sel_sequencer

Overview:
Round-robin channel sequencer that generates the 2-bit select for the downstream 4:1 mux (inputs j/k/l/m map to channels 0/1/2/3).
- Four request lines compete for the mux; one channel is granted at a time.
- Each grant lasts a bounded number of cycles (or less if the request drops); then the grant rotates fairly.
- sel drives the mux select directly; grant/busy/done feed the source-side control.

Parameters:
HOLD_CYCLES, 4, maximum cycles a grant is held; legal range 1..255
CNT_W, $clog2(HOLD_CYCLES+1), hold-counter width (derived; do not override)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  synchronous reset, active-high
req  input  4  per-channel request; bit i = mux input i
sel  output 2  mux select, registered
grant  output 4  one-hot grant, registered; all zero when idle
busy  output 1  high while any grant is active
done  output 1  one-cycle pulse: previous grant released this cycle

Behaviour:
- All outputs registered. On a rst edge: sel=0, grant=0, busy=0, done=0, rotation pointer ptr=0, cnt=0, state IDLE. rst has priority over all other events, including mid-grant; no done pulse is issued for a grant killed by reset.
- States: IDLE and GRANT.
- Arbitration (combinational pick):
  - Search req starting at ptr, ascending mod 4; the first set bit wins.
  - If req==0 there is no winner.
- IDLE: at an edge with a winner w:
  - Next cycle: grant=onehot(w), sel=w, busy=1, cnt=0, state GRANT.
  - Latency from req sampled to grant visible is 1 cycle.
  - With no winner: stay in IDLE; sel holds its last value; grant=0.
- GRANT: each edge, cnt increments. Release occurs at the edge where either:
  - (a) cnt==HOLD_CYCLES-1 (expiry), or
  - (b) req[sel]==0 (early drop).
  - If (a) and (b) coincide, that is a single release.
- On release:
  - ptr <= sel+1 (mod 4, 2-bit wrap 3->0).
  - done=1 for exactly the following cycle.
  - Re-arbitrate in the same edge with the updated pointer. The requester being released is therefore lowest priority.
  - If there is a winner: grant/sel switch to it, cnt=0, stay GRANT, busy stays 1. There is no idle bubble; done and the new grant coincide.
  - If there is no winner: grant=0, busy=0, state IDLE. sel keeps the released channel.
- Without early drop, a grant is asserted for exactly HOLD_CYCLES consecutive cycles.
- Single requester that keeps req high: it is re-granted back-to-back; done pulses every HOLD_CYCLES cycles; sel is unchanged.
- Changes to req of non-granted channels during GRANT do not affect the current grant.
- Invariants: grant is always one-hot or zero; grant!=0 iff busy; when busy, sel==index(grant).

Decomposition:
- Package rr_sel_pkg holds:
  - N_CH=4
  - SEL_W=2
  - state enum {ST_IDLE, ST_GRANT}
  - function onehot(sel) -> [3:0]
- Sub-module rr_pick (purely combinational): inputs req[3:0] and ptr[1:0]; outputs valid and win[1:0]. It is instantiated once.
- Top level holds the FSM, the hold counter and the pointer registers.

Test Plan:
- Reset/idle: assert rst 2 cycles with req=4'b1111, then release rst and drive req=0 -> sel=0, grant=0, busy=0, done=0 throughout.
- Single request, HOLD_CYCLES=4: req=4'b0100 held high -> grant=4'b0100 and sel=2 one cycle later. done pulses every 4 cycles; sel is stable; busy stays 1.
- Rotation: req=4'b1111 continuously from reset -> sel sequence 0,1,2,3,0. Each value lasts 4 cycles; done is high on each switch cycle.
- Early drop: grant on ch1; drop req[1] after 2 cycles while req=4'b1000 -> the next cycle shows done=1 and grant=4'b1000, sel=3. Ch3 then holds for a full 4 cycles.
- Wrap/fairness: ptr at 3 after a ch2 release with req=4'b1001 -> ch3 is granted. After it is released, ch0 is granted, not ch3 again.
- Reset mid-grant: rst asserted on the 2nd cycle of a ch2 grant -> the next cycle shows all outputs at reset values, no done pulse, and ptr=0. A following req=4'b0110 is granted to ch1.
